// File: rtl/alarm_sched_pkg.sv
// Shared types for the alarm output scheduler: FSM states, src encodings and helpers.
package alarm_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WARN     = 3'd1,
    ST_ROB      = 3'd2,
    ST_FIRE     = 3'd3,
    ST_SILENCED = 3'd4
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_WARN = 2'd1;
  localparam logic [1:0] SRC_ROB  = 2'd2;
  localparam logic [1:0] SRC_FIRE = 2'd3;

  // The src code doubles as the priority rank of an alarm state.
  function automatic logic [1:0] state_src(state_t s);
    case (s)
      ST_WARN: return SRC_WARN;
      ST_ROB:  return SRC_ROB;
      ST_FIRE: return SRC_FIRE;
      default: return SRC_NONE;
    endcase
  endfunction

  function automatic state_t req_state(logic io, logic ao, logic lo);
    if (io)      return ST_FIRE;
    else if (ao) return ST_ROB;
    else if (lo) return ST_WARN;
    else         return ST_IDLE;
  endfunction

endpackage

// File: rtl/alarm_sched_if.sv
// Bundle between the security FSM (master) and the alarm scheduler (slave).
// Level-signalled: no valid/ready; every input is sampled on each rising edge and
// every output is a registered level that changes only on a rising edge.
interface alarm_sched_if;
  logic       io;
  logic       ao;
  logic       lo;
  logic       pw;
  logic       sil;
  logic       siren;
  logic       strobe;
  logic [1:0] src;
  logic       busy;

  modport master (output io, ao, lo, pw, sil, input siren, strobe, src, busy);
  modport slave  (input io, ao, lo, pw, sil, output siren, strobe, src, busy);
endinterface

// File: rtl/alarm_pulse_gen.sv
// Half-period counter plus toggle flop; clear restarts the pattern with the toggle high.
module alarm_pulse_gen #(
  parameter int PULSE_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tgl
);
  localparam int CW = (PULSE_HALF > 1) ? $clog2(PULSE_HALF) : 1;
  localparam logic [CW-1:0] TERM = CW'(PULSE_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_tgl;
  logic          w_tgl_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_tgl_nxt = r_tgl;
    if (i_clr) begin
      w_cnt_nxt = '0;
      w_tgl_nxt = 1'b1;
    end else if (i_en) begin
      if (r_cnt == TERM) begin
        w_cnt_nxt = '0;
        w_tgl_nxt = ~r_tgl;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_tgl <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tgl <= w_tgl_nxt;
    end
  end

  // Exposes the value the toggle takes at the coming edge so the caller can
  // register its outputs on the same edge as its state.
  assign o_tgl = w_tgl_nxt;

endmodule

// File: rtl/alarm_sched.sv
// Shares one siren and one strobe among fire/robbery/warning requests with priority,
// minimum hold, robbery pulsing and password-qualified silencing.
// Optional build macro: ALARM_SCHED_STROBE_BLINK_EN (strobe blinks in active states).
module alarm_sched
  import alarm_sched_pkg::*;
#(
  parameter int PULSE_HALF = 4,
  parameter int MIN_HOLD   = 8
) (
  input  logic                clk,
  input  logic                rst,
  alarm_sched_if.slave        alarm_bus,
  output state_t              o_dbg_state
);
  localparam int HW = $clog2(MIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  state_t       r_state;
  state_t       w_state_nxt;
  state_t       w_hi;
  logic [HW-1:0] r_hold;
  logic [HW-1:0] w_hold_inc;
  logic         w_hold_done;
  logic         w_sil_ok;
  logic         w_any;
  logic         w_entry;
  logic [1:0]   r_sil_src;
  logic         w_pulse_en;
  logic         w_tgl_nxt;
  logic         w_strobe_on;
  logic         w_siren;
  logic         w_strobe;
  logic [1:0]   w_src;
  logic         r_siren;
  logic         r_strobe;
  logic [1:0]   r_src;
  logic         r_busy;

  always_comb begin
    w_any       = alarm_bus.io | alarm_bus.ao | alarm_bus.lo;
    w_hi        = req_state(alarm_bus.io, alarm_bus.ao, alarm_bus.lo);
    w_sil_ok    = alarm_bus.sil & alarm_bus.pw;
    w_hold_inc  = (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;
    // Done on the edge that ends the MIN_HOLD-th cycle in the state.
    w_hold_done = (w_hold_inc == HOLD_MAX);
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_hi;
      ST_WARN: begin
        if (alarm_bus.io | alarm_bus.ao)           w_state_nxt = w_hi;
        else if (w_sil_ok)                         w_state_nxt = ST_SILENCED;
        else if (w_hold_done && !alarm_bus.lo)     w_state_nxt = w_hi;
      end
      ST_ROB: begin
        if (alarm_bus.io)                          w_state_nxt = ST_FIRE;
        else if (w_sil_ok)                         w_state_nxt = ST_SILENCED;
        else if (w_hold_done && !alarm_bus.ao)     w_state_nxt = w_hi;
      end
      ST_FIRE: begin
        if (w_sil_ok && !alarm_bus.io)             w_state_nxt = ST_SILENCED;
        else if (w_hold_done && !alarm_bus.io)     w_state_nxt = w_hi;
      end
      ST_SILENCED: begin
        if (state_src(w_hi) > r_sil_src)           w_state_nxt = w_hi;
        else if (!w_any)                           w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_entry = (w_state_nxt != r_state);
  end

`ifdef ALARM_SCHED_STROBE_BLINK_EN
  assign w_pulse_en  = (w_state_nxt == ST_WARN) || (w_state_nxt == ST_ROB) ||
                       (w_state_nxt == ST_FIRE);
  assign w_strobe_on = w_tgl_nxt;
`else
  assign w_pulse_en  = (w_state_nxt == ST_ROB);
  assign w_strobe_on = 1'b1;
`endif

  alarm_pulse_gen #(.PULSE_HALF(PULSE_HALF)) u_pulse (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_entry),
    .i_en  (w_pulse_en),
    .o_tgl (w_tgl_nxt)
  );

  always_comb begin
    w_siren  = 1'b0;
    w_strobe = 1'b0;
    w_src    = state_src(w_state_nxt);
    case (w_state_nxt)
      ST_FIRE: begin w_siren = 1'b1;      w_strobe = w_strobe_on; end
      ST_ROB:  begin w_siren = w_tgl_nxt; w_strobe = w_strobe_on; end
      ST_WARN: begin w_siren = 1'b0;      w_strobe = w_strobe_on; end
      default: begin w_siren = 1'b0;      w_strobe = 1'b0;        end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_sil_src <= SRC_NONE;
      r_siren   <= 1'b0;
      r_strobe  <= 1'b0;
      r_src     <= SRC_NONE;
      r_busy    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_hold   <= w_entry ? '0 : w_hold_inc;
      // Remember what was silenced so only a strictly higher request can break through.
      if (w_entry && (w_state_nxt == ST_SILENCED))
        r_sil_src <= state_src(r_state);
      r_siren  <= w_siren;
      r_strobe <= w_strobe;
      r_src    <= w_src;
      r_busy   <= (w_state_nxt != ST_IDLE);
    end
  end

  assign alarm_bus.siren  = r_siren;
  assign alarm_bus.strobe = r_strobe;
  assign alarm_bus.src    = r_src;
  assign alarm_bus.busy   = r_busy;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_alarm_sched.sv
// Directed bench for alarm_sched: an abstract level/age model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_alarm_sched;
  import alarm_sched_pkg::*;

  localparam int PH = 4;
  localparam int MH = 8;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  alarm_sched_if bus();

  alarm_sched #(.PULSE_HALF(PH), .MIN_HOLD(MH)) dut (
    .clk         (clk),
    .rst         (rst),
    .alarm_bus   (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_lvl: active alarm rank (0 none, 1 warn, 2 rob, 3 fire); m_age: cycles since entry.
  int m_lvl, m_sil_lvl, m_age;
  bit m_sil;

  task automatic m_enter(int l);
    m_lvl = l;
    m_sil = 1'b0;
    m_age = 0;
  endtask

  task automatic model_step();
    int hi;
    bit cur;
    hi  = bus.io ? 3 : bus.ao ? 2 : bus.lo ? 1 : 0;
    cur = (m_lvl == 3) ? bus.io : (m_lvl == 2) ? bus.ao : (m_lvl == 1) ? bus.lo : 1'b0;
    if (m_sil) begin
      if (hi > m_sil_lvl) m_enter(hi);
      else if (hi == 0)   m_enter(0);
      else                m_age++;
    end else if (m_lvl == 0) begin
      if (hi != 0) m_enter(hi);
    end else if (hi > m_lvl) begin
      m_enter(hi);
    end else if (bus.sil && bus.pw && !(m_lvl == 3 && bus.io)) begin
      m_sil = 1'b1; m_sil_lvl = m_lvl; m_lvl = 0; m_age = 0;
    end else if (!cur && (m_age + 1 >= MH)) begin
      m_enter(hi);
    end else begin
      m_age++;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lvl = 0; m_sil = 1'b0; m_sil_lvl = 0; m_age = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(posedge clk) begin
    bit phase_on;
    #1;
    phase_on = ((m_age / PH) % 2) == 0;
    check("model_busy",  bus.busy,  (m_sil || m_lvl != 0));
    check("model_src",   bus.src,   m_lvl);
    check("model_siren", bus.siren, (m_lvl == 3) || (m_lvl == 2 && phase_on));
`ifdef ALARM_SCHED_STROBE_BLINK_EN
    check("model_strobe", bus.strobe, (m_lvl != 0) && phase_on);
`else
    check("model_strobe", bus.strobe, (m_lvl != 0));
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic f, logic a, logic l);
    bus.io = f; bus.ao = a; bus.lo = l;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [19:0] pat20;
    logic [11:0] pat12;
    int cnt;
    bit all_one, any_siren;

    rst = 1'b1;
    set_req(0, 0, 0);
    bus.pw = 1'b0; bus.sil = 1'b0;
    cyc(2);
    check("rst_siren",  bus.siren,  0);
    check("rst_strobe", bus.strobe, 0);
    check("rst_src",    bus.src,    0);
    check("rst_busy",   bus.busy,   0);
    rst = 1'b0;
    cyc(2);

    // 1: single-cycle warning request holds WARN for exactly MIN_HOLD cycles
    set_req(0, 0, 1);
    cyc(1);
    set_req(0, 0, 0);
    check("t1_src",    bus.src,    1);
    check("t1_strobe", bus.strobe, 1);
    check("t1_busy",   bus.busy,   1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.busy) cnt++;
      if (i < 11) cyc(1);
    end
    check("t1_hold_len", cnt, 8);
    check("t1_idle_src", bus.src, 0);
    cyc(2);

    // 2: robbery pulse pattern
    set_req(0, 1, 0);
    all_one = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      pat20[19-i] = bus.siren;
      if (!bus.strobe || bus.src != 2'd2) all_one = 1'b0;
    end
    check("t2_siren_pattern", pat20, 20'b1111_0000_1111_0000_1111);
    check("t2_strobe_src", all_one, 1);
    set_req(0, 0, 0);
    cyc(3);

    // 3: preemption by fire 3 cycles into ROB; simultaneous requests pick fire
    set_req(0, 1, 0);
    cyc(3);
    bus.io = 1'b1;
    cyc(1);
    check("t3_preempt_src",   bus.src,   3);
    check("t3_preempt_siren", bus.siren, 1);
    check("t3_preempt_strb",  bus.strobe, 1);
    set_req(0, 0, 0);
    cyc(10);
    check("t3_back_idle", bus.src, 0);
    set_req(1, 1, 1);
    cyc(1);
    check("t3_priority", bus.src, 3);
    set_req(0, 0, 0);
    cyc(10);

    // 4: silence rules
    set_req(0, 1, 0);
    cyc(3);
    bus.sil = 1'b1; bus.pw = 1'b0;
    cyc(1);
    check("t4_sil_no_pw", bus.src, 2);
    bus.pw = 1'b1;
    cyc(1);
    bus.sil = 1'b0; bus.pw = 1'b0;
    check("t4_silenced_src",  bus.src,  0);
    check("t4_silenced_busy", bus.busy, 1);
    check("t4_silenced_out",  {bus.siren, bus.strobe}, 2'b00);
    cyc(3);
    check("t4_sil_held", bus.busy, 1);
    bus.ao = 1'b0;
    cyc(1);
    check("t4_sil_release", bus.busy, 0);
    bus.io = 1'b1;
    cyc(2);
    bus.sil = 1'b1; bus.pw = 1'b1;
    cyc(2);
    check("t4_fire_unsilenced", bus.src, 3);
    bus.sil = 1'b0; bus.pw = 1'b0;
    bus.io = 1'b0;
    cyc(10);

    // 5: asynchronous reset in FIRE
    bus.io = 1'b1;
    cyc(2);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_out", {bus.siren, bus.strobe, bus.busy, bus.src}, 5'b0);
    #1;
    rst = 1'b0;
    cyc(1);
    check("t5_reeval_src", bus.src, 3);
    bus.io = 1'b0;
    cyc(10);

    // 6: strobe under a held warning request
    bus.lo = 1'b1;
    any_siren = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      pat12[11-i] = bus.strobe;
      if (bus.siren) any_siren = 1'b1;
    end
`ifdef ALARM_SCHED_STROBE_BLINK_EN
    check("t6_strobe_blink", pat12, 12'b1111_0000_1111);
`else
    check("t6_strobe_steady", pat12, 12'b1111_1111_1111);
`endif
    check("t6_siren_quiet", any_siren, 0);
    bus.lo = 1'b0;
    cyc(10);
    check("t6_final_idle", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_sched.md
# alarm_sched

Output scheduler that shares one siren driver and one strobe driver among the three alarm requests produced by the security state machine: fire (`io`), robbery (`ao`) and warning lights (`lo`). It resolves priority, enforces a minimum on-time, generates the robbery pulse pattern, and handles password-qualified silencing. It sits between the security FSM outputs and the physical annunciator drivers.

## Interface
- `PULSE_HALF`, default 4: cycles per half-period of the robbery siren pulse; must be ≥ 1.
- `MIN_HOLD`, default 8: minimum cycles an active alarm state is held before it may drop or fall to a lower priority; must be ≥ 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `io` in 1: fire alarm request, level.
- `ao` in 1: robbery alarm request, level.
- `lo` in 1: warning-light request, level.
- `pw` in 1: correct-password indication, level.
- `sil` in 1: silence request, sampled each cycle.
- `siren` out 1: siren driver.
- `strobe` out 1: strobe driver.
- `src` out 2: active source, where 0 = none/silenced, 1 = warning, 2 = robbery, 3 = fire.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States are IDLE, WARN, ROB, FIRE and SILENCED.
- Priority is `io` > `ao` > `lo`. When several requests are present together, the highest one wins.
- **IDLE:** goes to the state of the highest asserted request. With no request it stays in IDLE.
- **Preemption:** a request of higher priority than the current state moves the FSM to that state on the next edge, whatever the hold count. This applies from WARN, ROB and SILENCED.
- **Hold:**
  - The hold counter clears on every state entry and saturates at `MIN_HOLD`.
  - Until saturation the state is kept, even if its own request drops.
  - After saturation, if the current request is low, the FSM goes to the highest remaining request, or to IDLE if there is none.
- **Silence:**
  - `sil & pw` in WARN or ROB goes to SILENCED.
  - In FIRE it is honoured only when `io` = 0; fire is never silenced while smoke persists.
  - `sil` without `pw` is ignored.
  - Preemption beats silence in the same cycle.
- **SILENCED:** held while any request is asserted. It returns to IDLE on the first cycle where `io`, `ao` and `lo` are all 0.
- **Outputs:**
  - FIRE: `siren` = 1, `strobe` = 1.
  - ROB: `siren` = pulse, `strobe` = 1.
  - WARN: `siren` = 0, `strobe` = 1.
  - IDLE and SILENCED: both 0.
- **Pulse:**
  - The counter clears on ROB entry.
  - `siren` is 1 for the first `PULSE_HALF` cycles, then toggles every `PULSE_HALF` cycles while in ROB.
- **Counter widths:**
  - Hold counter: `$clog2(MIN_HOLD+1)`.
  - Pulse counter: `$clog2(PULSE_HALF)`, minimum 1.
  - Both are unsigned, with no wrap beyond their terminal values.

## Timing
- All outputs are registered and updated on the same edge as the state.
- Latency from a request being sampled high at edge k to the state and outputs changing is 1 cycle: the new values are visible after edge k.
- Reset values are: state = IDLE; `siren`, `strobe` and `busy` = 0; `src` = 0; both counters = 0.
- Reset mid-operation clears everything immediately, without waiting for a clock edge. The first evaluation occurs on the first edge after `rst` falls.
- Preemption restarts the hold count at 0 in the new state.
- A request that pulses for a single cycle still produces `MIN_HOLD` cycles of its state.

## Configuration
- Macro: `ALARM_SCHED_STROBE_BLINK_EN`.
- When defined, `strobe` toggles at the `PULSE_HALF` rate in WARN, ROB and FIRE. The pulse counter then runs in all active states and clears on each state entry, with `strobe` = 1 on entry.
- When undefined, `strobe` is steady as listed in Operation, and the pulse counter runs only in ROB.

## Structure
- Package `alarm_sched_pkg` holds:
  - the state enum (IDLE, WARN, ROB, FIRE, SILENCED);
  - the `src` encodings `SRC_NONE`, `SRC_WARN`, `SRC_ROB`, `SRC_FIRE`.
- Sub-module `alarm_pulse_gen` contains the pulse counter and toggle flop, with `clk`, `rst`, a clear input, an enable input and a toggle output, parameterised by `PULSE_HALF`.
- The FSM, the hold counter and the output registers live in `alarm_sched`.

## Test plan
All scenarios use `PULSE_HALF` = 4 and `MIN_HOLD` = 8.

1. **Reset and single request.** Assert `rst` then release it; raise `lo` for 1 cycle. Required: `src` = 1, `strobe` = 1 and `busy` = 1 one cycle later, held for exactly 8 cycles, then IDLE with all outputs 0.
2. **Robbery pulse.** Hold `ao` = 1 for 20 cycles. Required: `src` = 2; `siren` follows the pattern 1111 0000 1111 0000 1111 from entry; `strobe` stays 1.
3. **Preemption and priority.** With `ao` held and 3 cycles into ROB, raise `io`. Required: FIRE on the next edge with `siren` = `strobe` = 1. Also, `io`, `ao` and `lo` raised in the same cycle from IDLE must go to FIRE.
4. **Silence rules.** In ROB, assert `sil` with `pw` = 0: no change. Then assert `sil` with `pw` = 1: SILENCED with outputs 0, held while `ao` = 1, and IDLE one cycle after `ao` drops. In FIRE with `io` = 1, `sil & pw` must be ignored.
5. **Async reset mid-operation.** In FIRE, pulse `rst` between clock edges. Required: all outputs and `busy` go to 0 before the next edge; the first edge after release re-evaluates the requests.
6. **Blink build.** Rebuild with `ALARM_SCHED_STROBE_BLINK_EN` defined and hold `lo` = 1. Required: `strobe` toggles 1111 0000 1111 while `siren` stays 0.
